// File: rtl/pll_rstgen_pkg.sv
// Shared types and helpers for the PLL reset / baud timebase generator.
// Optional feature macro: PLL_RSTGEN_LOSS_CNT_EN (lock-loss debug counter).
package pll_rstgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } rstgen_state_t;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

  // Accumulator must hold acc + increment without overflow, plus one spare bit.
  function automatic int baud_acc_width(input int clk_freq_hz, input int baud);
    return $clog2(clk_freq_hz + 16 * baud) + 1;
  endfunction

endpackage

// File: rtl/pll_rst_gen_baud_tick.sv
// Fractional accumulator producing a 16x-oversampling baud enable.
// Cleared and silent whenever en is low, so ticks restart phase-aligned on RUN entry.
module baud_tick_gen
  import pll_rstgen_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int ACC_W = baud_acc_width(CLK_FREQ_HZ, BAUD);
  localparam logic [ACC_W-1:0] INC   = ACC_W'(16 * BAUD);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FREQ_HZ);

  logic [ACC_W-1:0] acc_q, acc_d, sum;

  // Next accumulator value and tick; tick is combinational so it drops the instant en drops.
  always_comb begin
    sum   = acc_q + INC;
    tick  = en && (sum >= LIMIT);
    acc_d = '0;
    if (en) begin
      acc_d = tick ? (sum - LIMIT) : sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/pll_rst_gen.sv
// PLL lock qualifier, system reset release and baud timebase.
// Optional feature macro: PLL_RSTGEN_LOSS_CNT_EN builds the lock-loss counter;
// otherwise lock_lost_cnt reads constant zero.
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | just out of rst, one cycle before watching lock
// WAIT_LOCK  | waiting for synchronized lock
// QUALIFY    | lock must stay high LOCK_STABLE_CYCLES cycles
// HOLD       | lock qualified, sys_rst held RST_HOLD_CYCLES
// RUN        | sys_rst released, ready high, baud ticking
module pll_rst_gen
  import pll_rstgen_pkg::*;
#(
  parameter int CLK_FREQ_HZ        = 50_000_000,
  parameter int BAUD               = 115200,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       sys_rst,
  output logic       ready,
  output logic       baud_tick,
  output logic [7:0] lock_lost_cnt
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             lock_s;
  rstgen_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;

  assign sync_d = {sync_q[0], pll_lock};
  assign lock_s = sync_q[1];

  // Sequence state machine; cnt is cleared on every exit so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == QUAL_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  // Synchronizer, FSM and registered reset/ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;

`ifdef PLL_RSTGEN_LOSS_CNT_EN
  logic       loss_hit;
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Only drops seen while running count; drops during QUALIFY/HOLD are ordinary start-up bounce.
  assign loss_hit = (state_q == ST_RUN) && !lock_s;

  // Saturating lock-loss count.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_hit && (loss_cnt_q != LOSS_CNT_MAX)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  // Lock-loss counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) loss_cnt_q <= 8'd0;
    else     loss_cnt_q <= loss_cnt_d;
  end

  assign lock_lost_cnt = loss_cnt_q;
`else
  assign lock_lost_cnt = 8'd0;
`endif

  baud_tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .tick (baud_tick)
  );

endmodule

// File: tb/tb_pll_rst_gen.sv
// Bench for pll_rst_gen: lock qualification, bounce, RUN loss, baud rate,
// async reset and counter saturation. Honours PLL_RSTGEN_LOSS_CNT_EN.
module tb_pll_rst_gen;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD_R   = 115200;
  localparam int LSC      = 8;
  localparam int RHC      = 4;
  localparam int SYNC_LAT = 2;
  localparam int REL_LAT  = SYNC_LAT + LSC + RHC + 1;
  localparam int LOSS_LAT = SYNC_LAT + 1;
  localparam int BAUD_CYC = 50000;
`ifdef PLL_RSTGEN_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       sys_rst;
  logic       ready;
  logic       baud_tick;
  logic [7:0] lock_lost_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int exp_q[$];
  int tick_q[$];
  int loss_seen = 0;
  int cyc;

  pll_rst_gen #(
    .CLK_FREQ_HZ        (CLK_HZ),
    .BAUD               (BAUD_R),
    .LOCK_STABLE_CYCLES (LSC),
    .RST_HOLD_CYCLES    (RHC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .baud_tick     (baud_tick),
    .lock_lost_cnt (lock_lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_loss(input int n);
    if (!LOSS_EN) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  // Called at a negedge; counts posedges until sys_rst reaches val or budget runs out.
  task automatic wait_rst_level(input logic val, input int budget, output int n);
    n = 0;
    while (sys_rst !== val && n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic lock_drop();
    int c;
    pll_lock = 1'b0;
    exp_q.push_back(LOSS_LAT);
    wait_rst_level(1'b1, 20, c);
    chk("loss_lat", c, exp_q.pop_front());
    loss_seen++;
    exp_q.push_back(exp_loss(loss_seen));
    chk("loss_cnt", int'(lock_lost_cnt), exp_q.pop_front());
    exp_q.push_back(0);
    chk("loss_ready", int'(ready), exp_q.pop_front());
  endtask

  task automatic lock_raise(input string tag);
    int c;
    pll_lock = 1'b1;
    exp_q.push_back(REL_LAT);
    wait_rst_level(1'b0, 60, c);
    chk(tag, c, exp_q.pop_front());
    exp_q.push_back(1);
    chk("rel_ready", int'(ready), exp_q.pop_front());
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int last;
    longint inc;
    rst      = 1'b1;
    pll_lock = 1'b0;
    #2;
    exp_q.push_back(1); chk("por_sys_rst", int'(sys_rst), exp_q.pop_front());
    exp_q.push_back(0); chk("por_ready", int'(ready), exp_q.pop_front());
    exp_q.push_back(0); chk("por_tick", int'(baud_tick), exp_q.pop_front());
    exp_q.push_back(0); chk("por_cnt", int'(lock_lost_cnt), exp_q.pop_front());
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.push_back(1); chk("nolock_sys_rst", int'(sys_rst), exp_q.pop_front());
    exp_q.push_back(0); chk("nolock_ready", int'(ready), exp_q.pop_front());

    // Reset and lock.
    lock_raise("rel_lat_first");

    // Baud rate: this negedge is RUN cycle 0.
    inc = 16 * BAUD_R;
    for (int n = 0; n < BAUD_CYC; n++) begin
      if (((longint'(n) + 1) * inc) / CLK_HZ != (longint'(n) * inc) / CLK_HZ)
        tick_q.push_back(n);
    end
    exp_q.push_back(tick_q.size());
    ticks = 0;
    last  = -1;
    for (int n = 0; n < BAUD_CYC; n++) begin
      if (baud_tick === 1'b1) begin
        ticks++;
        chk("tick_pos", n, (tick_q.size() > 0) ? tick_q.pop_front() : -1);
        if (last >= 0) chk("tick_gap", int'((n - last) == 27 || (n - last) == 28), 1);
        last = n;
      end
      @(negedge clk);
    end
    chk("tick_count", ticks, exp_q.pop_front());
    chk("tick_missing", tick_q.size(), 0);

    // Lock loss in RUN.
    for (int i = 0; i < 3; i++) begin
      lock_drop();
      lock_raise("rel_lat_loss");
    end

    // Bounce: one-cycle drop after 5 QUALIFY cycles restarts qualification.
    lock_drop();
    pll_lock = 1'b1;
    repeat (5) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    exp_q.push_back(REL_LAT);
    wait_rst_level(1'b0, 60, cyc);
    chk("rel_lat_bounce", cyc, exp_q.pop_front());

    // Async reset between edges while running.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(1); chk("arst_sys_rst", int'(sys_rst), exp_q.pop_front());
    exp_q.push_back(0); chk("arst_ready", int'(ready), exp_q.pop_front());
    exp_q.push_back(0); chk("arst_tick", int'(baud_tick), exp_q.pop_front());
    exp_q.push_back(0); chk("arst_cnt", int'(lock_lost_cnt), exp_q.pop_front());
    loss_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(REL_LAT);
    wait_rst_level(1'b0, 60, cyc);
    chk("rel_lat_rst", cyc, exp_q.pop_front());

    // Saturation.
    for (int i = 0; i < 260; i++) begin
      lock_drop();
      lock_raise("rel_lat_sat");
    end
    exp_q.push_back(LOSS_EN ? 255 : 0);
    chk("sat_final", int'(lock_lost_cnt), exp_q.pop_front());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
